// File: rtl/io_irq_pkg.sv
// Shared definitions for the io_irq_ctrl interrupt controller:
// register offsets, VEC field layout and the default I/O base address.
package io_irq_pkg;

  typedef enum logic [1:0] {
    REG_PEND = 2'd0,
    REG_MASK = 2'd1,
    REG_MODE = 2'd2,
    REG_VEC  = 2'd3
  } reg_off_e;

  localparam int unsigned VEC_VALID_BIT = 7;
  localparam logic [7:0]  DEF_BASE_ADDR = 8'hF0;

endpackage

// File: rtl/io_irq_ctrl_if.sv
// I/O port bus between the core (master) and the interrupt controller (slave).
interface io_irq_ctrl_if;
  logic [7:0] io_addr_i;
  logic [7:0] io_data_i;
  logic       io_we_i;
  logic [7:0] io_rdata_o;
  logic       io_sel_o;

  modport master (
    output io_addr_i, io_data_i, io_we_i,
    input  io_rdata_o, io_sel_o
  );

  modport slave (
    input  io_addr_i, io_data_i, io_we_i,
    output io_rdata_o, io_sel_o
  );
endinterface

// File: rtl/io_irq_ctrl_src_cond.sv
// Per-source conditioning for io_irq_ctrl: optional 2-flop synchronizer
// (macro IRQ_SYNC_EN), edge history flop and the edge/level pending bit.
module irq_src_cond (
  input  logic clk_i,
  input  logic rst_i,      // asynchronous, active-low
  input  logic i_src,
  input  logic i_mode,     // current MODE bit: 1 = edge, 0 = level
  input  logic i_mode_nxt, // MODE bit after this edge (includes a write in flight)
  input  logic i_clr,      // W1C request for this bit
  output logic o_pend
);

  logic w_src;
  logic r_hist;
  logic r_pend;

`ifdef IRQ_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  // Two-stage synchronizer for asynchronous request lines
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_src;
      r_sync2 <= r_sync1;
    end
  end

  assign w_src = r_sync2;
`else
  assign w_src = i_src;
`endif

  // History always tracks the conditioned level so a level->edge switch
  // starts from the current level; the switch cycle clears pending.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_hist <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      r_hist <= w_src;
      if (!i_mode_nxt)
        r_pend <= w_src;
      else if (!i_mode)
        r_pend <= 1'b0;
      else
        r_pend <= (w_src & ~r_hist) | (r_pend & ~i_clr);
    end
  end

  assign o_pend = r_pend;

endmodule

// File: rtl/io_irq_ctrl.sv
// io_irq_ctrl: 8-source I/O-mapped interrupt controller driving the core's
// level irq input. Registers PEND/MASK/MODE/VEC at BASE_ADDR..BASE_ADDR+3.
// Optional macro IRQ_SYNC_EN adds a 2-flop synchronizer per source.
module io_irq_ctrl
  import io_irq_pkg::*;
#(
  parameter int unsigned NUM_SRC   = 8,
  parameter logic [7:0]  BASE_ADDR = DEF_BASE_ADDR
) (
  input  logic               clk_i,
  input  logic               rst_i,   // asynchronous, active-low
  input  logic [NUM_SRC-1:0] src_i,
  io_irq_ctrl_if.slave       bus,
  output logic               irq_o
);

  logic [NUM_SRC-1:0] r_mask;
  logic [NUM_SRC-1:0] r_mode;
  logic               r_irq;

  logic               w_sel;
  logic               w_wr;
  reg_off_e           w_off;
  logic [NUM_SRC-1:0] w_mode_nxt;
  logic [NUM_SRC-1:0] w_clr;
  logic [NUM_SRC-1:0] w_pend;
  logic [NUM_SRC-1:0] w_hit;
  logic [2:0]         w_idx;
  logic [7:0]         w_pend8;
  logic [7:0]         w_mask8;
  logic [7:0]         w_mode8;
  logic [7:0]         w_vec;
  logic [7:0]         w_rdata;

  assign w_sel = (bus.io_addr_i[7:2] == BASE_ADDR[7:2]);
  assign w_off = reg_off_e'(bus.io_addr_i[1:0]);
  assign w_wr  = bus.io_we_i & w_sel;

  assign w_mode_nxt = (w_wr && w_off == REG_MODE) ? bus.io_data_i[NUM_SRC-1:0] : r_mode;
  assign w_clr      = (w_wr && w_off == REG_PEND) ? bus.io_data_i[NUM_SRC-1:0] : '0;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    irq_src_cond u_cond (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .i_src      (src_i[g]),
      .i_mode     (r_mode[g]),
      .i_mode_nxt (w_mode_nxt[g]),
      .i_clr      (w_clr[g]),
      .o_pend     (w_pend[g])
    );
  end

  // MASK/MODE register writes and the registered core interrupt
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_mask <= '0;
      r_mode <= '1;
      r_irq  <= 1'b0;
    end else begin
      if (w_wr && w_off == REG_MASK)
        r_mask <= bus.io_data_i[NUM_SRC-1:0];
      r_mode <= w_mode_nxt;
      r_irq  <= |(w_pend & r_mask);
    end
  end

  assign w_hit = w_pend & r_mask;

  // Lowest-index enabled pending source; scanning downwards lets the lowest win
  always_comb begin
    w_idx = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (w_hit[NUM_SRC-1-i])
        w_idx = 3'(NUM_SRC-1-i);
    end
  end

  // Zero-extend register views and assemble VEC
  always_comb begin
    w_pend8 = '0;
    w_mask8 = '0;
    w_mode8 = '0;
    w_vec   = '0;
    w_pend8[NUM_SRC-1:0] = w_pend;
    w_mask8[NUM_SRC-1:0] = r_mask;
    w_mode8[NUM_SRC-1:0] = r_mode;
    w_vec[VEC_VALID_BIT] = |w_hit;
    w_vec[2:0]           = w_idx;
  end

  // Combinational read mux, zero when the address is outside the block
  always_comb begin
    w_rdata = '0;
    if (w_sel) begin
      case (w_off)
        REG_PEND: w_rdata = w_pend8;
        REG_MASK: w_rdata = w_mask8;
        REG_MODE: w_rdata = w_mode8;
        REG_VEC:  w_rdata = w_vec;
        default:  w_rdata = '0;
      endcase
    end
  end

  assign bus.io_rdata_o = w_rdata;
  assign bus.io_sel_o   = w_sel;
  assign irq_o          = r_irq;

endmodule
